// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit 4-stage core: widths, NOP encoding,
// fetch FSM states and opcode field positions used by decode.
package proc_pkg;

   localparam int ADDR_W  = 6;
   localparam int INSTR_W = 8;

   localparam logic [7:0] NOP_INSTR = 8'h00;

   // Opcode field within an instruction word, reserved for the decoder.
   localparam int OPC_HI = 7;
   localparam int OPC_LO = 6;

   typedef enum logic [1:0] {
      F_IDLE    = 2'd0,
      F_WAIT    = 2'd1,
      F_DISCARD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Prefetch queue: synchronous DEPTH x WIDTH FIFO with flush and occupancy count.
// Head is presented combinationally from the storage array; NOP when empty.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   import proc_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

   assign dout = empty ? WIDTH'(NOP_INSTR) : mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Fetch front end: one-outstanding req/ack reader of instruction memory feeding
// a prefetch queue toward IF/ID, with flush and redirect on a taken jump.
module instr_prefetch #(
   parameter int ADDR_W  = proc_pkg::ADDR_W,
   parameter int INSTR_W = proc_pkg::INSTR_W,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pc_src,
   input  logic [ADDR_W-1:0]  jmp_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   input  logic               instr_ready
);
   import proc_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t       state;
   fetch_state_t       state_nxt;
   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  req_addr;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   free_slots;
   logic               fifo_full;
   logic               fifo_empty;
   logic               can_issue;
   logic               push;
   logic               pop;

   // Issue uses the registered count only, so a same-cycle pop never frees a slot.
   assign free_slots = CNT_W'(DEPTH) - fifo_count;
   assign can_issue  = rst && !pc_src && (free_slots != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= F_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         F_IDLE:    if (can_issue) state_nxt = F_WAIT;
         F_WAIT: begin
            if (imem_ack)    state_nxt = F_IDLE;
            else if (pc_src) state_nxt = F_DISCARD;
         end
         F_DISCARD: if (imem_ack) state_nxt = F_IDLE;
         default:   state_nxt = F_IDLE;
      endcase
   end

   // The request is raised combinationally in IDLE so a 1-cycle memory
   // can ack in the following WAIT cycle, giving one fetch every 2 cycles.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = req_addr;
      push      = 1'b0;
      case (state)
         F_IDLE: begin
            imem_req  = can_issue;
            imem_addr = fetch_pc;
         end
         F_WAIT: begin
            imem_req = 1'b1;
            push     = imem_ack && !pc_src && !fifo_full;
         end
         F_DISCARD: imem_req = 1'b1;
         default: begin
            imem_req  = 1'b0;
            imem_addr = fetch_pc;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= '0;
         req_addr <= '0;
      end else begin
         if (pc_src)    fetch_pc <= jmp_addr;
         else if (push) fetch_pc <= fetch_pc + 1'b1;
         if (state == F_IDLE && can_issue) req_addr <= fetch_pc;
      end
   end

   assign instr_valid = !fifo_empty;
   assign pop         = instr_valid && instr_ready && !pc_src;

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (pc_src),
      .din   (imem_rdata),
      .dout  (instr),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: memory responder returns mem[a] = a + 8'h40
// after a programmable latency; expected values are hand-derived per cycle.
module tb_instr_prefetch;

   logic       clk;
   logic       rst;
   logic       pc_src;
   logic [5:0] jmp_addr;
   logic       imem_req;
   logic [5:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_rdata;
   logic       instr_valid;
   logic [7:0] instr;
   logic       instr_ready;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   int unsigned mem_lat = 1;
   bit          busy;
   int unsigned cnt;
   logic [5:0]  cap_addr;

   instr_prefetch #(
      .ADDR_W  (6),
      .INSTR_W (8),
      .DEPTH   (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_src      (pc_src),
      .jmp_addr    (jmp_addr),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory: sample request at negedge, ack mem_lat cycles after the request cycle.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 8'h00;
      busy       = 1'b0;
      cnt        = 0;
      cap_addr   = '0;
      forever begin
         @(negedge clk);
         if (!rst) busy = 1'b0;
         else if (!busy && imem_req && !imem_ack) begin
            busy     = 1'b1;
            cnt      = mem_lat;
            cap_addr = imem_addr;
         end
         @(posedge clk);
         #1;
         imem_ack = 1'b0;
         if (busy) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = {2'b00, cap_addr} + 8'h40;
               busy       = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) cyc();
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   // Ends at drive time of cycle C0, the first cycle with rst released.
   task automatic do_reset();
      rst      = 1'b0;
      pc_src   = 1'b0;
      jmp_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst         = 1'b0;
      pc_src      = 1'b0;
      jmp_addr    = '0;
      instr_ready = 1'b1;

      // 1: reset values, then streaming with 1-cycle memory and ready=1
      mem_lat = 1;
      neg();
      chk("rst_req",   imem_req,    0);
      chk("rst_addr",  imem_addr,   0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr,       0);
      cyc();
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         int unsigned ev;
         if (c != 0) cyc();
         neg();
         ev = (c >= 2 && (c % 2) == 0) ? 1 : 0;
         chk($sformatf("t1_req_c%0d", c),   imem_req,    1);
         chk($sformatf("t1_addr_c%0d", c),  imem_addr,   c / 2);
         chk($sformatf("t1_valid_c%0d", c), instr_valid, ev);
         chk($sformatf("t1_instr_c%0d", c), instr,       ev != 0 ? 8'h40 + c / 2 - 1 : 0);
      end

      // 2: ready=0 fills the queue with exactly 4 fetches, then one pop re-opens issue
      cyc();
      mem_lat     = 1;
      instr_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c != 0) cyc();
         neg();
         chk($sformatf("t2_req_c%0d", c),   imem_req,    c < 8 ? 1 : 0);
         chk($sformatf("t2_addr_c%0d", c),  imem_addr,   c < 8 ? c / 2 : 4);
         chk($sformatf("t2_valid_c%0d", c), instr_valid, c >= 2 ? 1 : 0);
         chk($sformatf("t2_instr_c%0d", c), instr,       c >= 2 ? 8'h40 : 0);
      end
      cyc();
      instr_ready = 1'b1;
      neg();
      chk("t2_pop_instr", instr,    8'h40);
      chk("t2_pop_req",   imem_req, 0);
      cyc();
      instr_ready = 1'b0;
      neg();
      chk("t2_after_instr", instr,     8'h41);
      chk("t2_after_req",   imem_req,  1);
      chk("t2_after_addr",  imem_addr, 4);

      // 3: jump while WAIT with 3-cycle memory; stale response discarded
      cyc();
      mem_lat     = 3;
      instr_ready = 1'b0;
      do_reset();
      neg();
      chk("t3_c0_addr", imem_addr, 0);
      cycles(4);
      neg();
      chk("t3_c4_instr", instr,     8'h40);
      chk("t3_c4_addr",  imem_addr, 1);
      cyc();
      pc_src   = 1'b1;
      jmp_addr = 6'h20;
      neg();
      chk("t3_c5_req",  imem_req,  1);
      chk("t3_c5_addr", imem_addr, 1);
      cyc();
      pc_src = 1'b0;
      neg();
      chk("t3_flush_valid", instr_valid, 0);
      chk("t3_flush_instr", instr,       0);
      chk("t3_disc_req",    imem_req,    1);
      chk("t3_disc_addr",   imem_addr,   1);
      cyc();
      neg();
      chk("t3_stale_ack_req", imem_req, 1);
      cyc();
      neg();
      chk("t3_stale_dropped", instr_valid, 0);
      chk("t3_redir_req",     imem_req,    1);
      chk("t3_redir_addr",    imem_addr,   6'h20);
      cycles(4);
      neg();
      chk("t3_first_valid", instr_valid, 1);
      chk("t3_first_instr", instr,       8'h60);

      // 4: jump coincides with ack and with pop
      cyc();
      mem_lat     = 1;
      instr_ready = 1'b0;
      do_reset();
      cycles(3);
      pc_src      = 1'b1;
      jmp_addr    = 6'h15;
      instr_ready = 1'b1;
      neg();
      chk("t4_c3_instr", instr, 8'h40);
      cyc();
      pc_src      = 1'b0;
      instr_ready = 1'b0;
      neg();
      chk("t4_empty_valid", instr_valid, 0);
      chk("t4_empty_instr", instr,       0);
      chk("t4_redir_req",   imem_req,    1);
      chk("t4_redir_addr",  imem_addr,   6'h15);
      cycles(2);
      neg();
      chk("t4_first_instr", instr,     8'h55);
      chk("t4_next_addr",   imem_addr, 6'h16);

      // 5: jump to 6'h3E in IDLE, sequential fetch wraps to 0
      cyc();
      mem_lat     = 1;
      instr_ready = 1'b1;
      do_reset();
      pc_src   = 1'b1;
      jmp_addr = 6'h3E;
      neg();
      chk("t5_idle_jump_req", imem_req, 0);
      cyc();
      pc_src = 1'b0;
      neg();
      chk("t5_addr_3e", imem_addr, 6'h3E);
      for (int k = 0; k < 3; k++) begin
         logic [5:0] ea;
         logic [5:0] pa;
         ea = 6'h3F + 6'(k);
         pa = 6'h3E + 6'(k);
         cycles(2);
         neg();
         chk($sformatf("t5_addr_k%0d", k),  imem_addr, ea);
         chk($sformatf("t5_instr_k%0d", k), instr,     {2'b00, pa} + 8'h40);
      end

      // 6: async reset while WAIT; the late ack afterwards is ignored
      cyc();
      mem_lat     = 2;
      instr_ready = 1'b0;
      do_reset();
      cycles(3);
      neg();
      chk("t6_c3_instr", instr,     8'h40);
      chk("t6_c3_addr",  imem_addr, 1);
      cyc();
      neg();
      chk("t6_wait_req", imem_req, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_req",   imem_req,    0);
      chk("t6_async_addr",  imem_addr,   0);
      chk("t6_async_valid", instr_valid, 0);
      chk("t6_async_instr", instr,       0);
      cyc();
      rst = 1'b1;
      neg();
      chk("t6_restart_req",  imem_req,    1);
      chk("t6_restart_addr", imem_addr,   0);
      chk("t6_late_ack_ign", instr_valid, 0);
      cycles(2);
      neg();
      chk("t6_c7_valid", instr_valid, 0);
      cycles(2);
      neg();
      chk("t6_c9_valid", instr_valid, 1);
      chk("t6_c9_instr", instr,       8'h40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
